// File: rtl/sysu_shift_reg_n.sv
// Parametrised universal shift register: hold / shift right / shift left / load, with clock enable,
// saturating shift counter and one-cycle DONE pulse. Optional rotate mode via SYSU_SHREG_ROTATE_EN.
module sysu_shift_reg_n #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic             CP,
   input  logic             RD,
   input  logic             CE,
   input  logic [1:0]       S,
   input  logic             DSR,
   input  logic             DSL,
   input  logic [WIDTH-1:0] D,
`ifdef SYSU_SHREG_ROTATE_EN
   input  logic             ROT,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_n,
   output logic [CW-1:0]    CNT,
   output logic             DONE
);

   localparam logic [CW-1:0] LP_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q_next;
   logic [CW-1:0]    w_cnt_next;
   logic             w_done_next;
   logic             w_fill_r;
   logic             w_fill_l;
   logic             w_shift;

`ifdef SYSU_SHREG_ROTATE_EN
   // Rotation recirculates the bit falling off the opposite end instead of the serial input
   assign w_fill_r = ROT ? r_q[WIDTH-1] : DSR;
   assign w_fill_l = ROT ? r_q[0]       : DSL;
`else
   assign w_fill_r = DSR;
   assign w_fill_l = DSL;
`endif

   always_comb begin
      w_q_next   = r_q;
      w_cnt_next = r_cnt;
      w_shift    = 1'b0;
      unique case (S)
         2'b01: begin
            w_q_next = {r_q[WIDTH-2:0], w_fill_r};
            w_shift  = 1'b1;
         end
         2'b10: begin
            w_q_next = {w_fill_l, r_q[WIDTH-1:1]};
            w_shift  = 1'b1;
         end
         2'b11: begin
            w_q_next   = D;
            w_cnt_next = '0;
         end
         default: ;
      endcase
      // Counter saturates at WIDTH; DONE fires only on the WIDTH-1 -> WIDTH transition
      w_done_next = w_shift && (r_cnt == LP_LAST);
      if (w_shift && (r_cnt != LP_FULL)) begin
         w_cnt_next = r_cnt + CW'(1);
      end
   end

   always_ff @(posedge CP or posedge RD) begin
      if (RD) begin
         r_q    <= RESET_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (CE) begin
         r_q    <= w_q_next;
         r_cnt  <= w_cnt_next;
         r_done <= w_done_next;
      end else begin
         r_done <= 1'b0;
      end
   end

   assign Q    = r_q;
   assign Q_n  = ~r_q;
   assign CNT  = r_cnt;
   assign DONE = r_done;

endmodule

// File: tb/tb_sysu_shift_reg_n.sv
// Self-checking bench for sysu_shift_reg_n (WIDTH=8, RESET_VAL=0): directed scenarios plus
// randomized traffic checked every cycle against an arithmetic model. Honours SYSU_SHREG_ROTATE_EN.
module tb_sysu_shift_reg_n;
   localparam int W  = 8;
   localparam int CW = 4;
   localparam int M  = 2 ** W;

   logic          CP = 1'b0;
   logic          RD;
   logic          CE;
   logic [1:0]    S;
   logic          DSR;
   logic          DSL;
   logic [W-1:0]  D;
   logic          ROT;
   logic [W-1:0]  Q;
   logic [W-1:0]  Q_n;
   logic [CW-1:0] CNT;
   logic          DONE;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int m_q, m_cnt, m_done;

   sysu_shift_reg_n #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .CP(CP), .RD(RD), .CE(CE), .S(S), .DSR(DSR), .DSL(DSL), .D(D),
`ifdef SYSU_SHREG_ROTATE_EN
      .ROT(ROT),
`endif
      .Q(Q), .Q_n(Q_n), .CNT(CNT), .DONE(DONE)
   );

   always #5 CP = ~CP;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: register as an integer modulo 2**W, counter as saturating integer
   always @(posedge CP or posedge RD) begin
      int fill;
      bit rot;
      if (RD) begin
         m_q = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (CE) begin
`ifdef SYSU_SHREG_ROTATE_EN
            rot = ROT;
`else
            rot = 1'b0;
`endif
            if (S == 2'b01 || S == 2'b10) begin
               if (S == 2'b01) begin
                  fill = rot ? (m_q / (M / 2)) : int'(DSR);
                  m_q  = (m_q * 2 + fill) % M;
               end else begin
                  fill = rot ? (m_q % 2) : int'(DSL);
                  m_q  = m_q / 2 + fill * (M / 2);
               end
               if (m_cnt < W) begin
                  m_cnt = m_cnt + 1;
                  if (m_cnt == W) m_done = 1;
               end
            end else if (S == 2'b11) begin
               m_q = int'(D); m_cnt = 0;
            end
         end
      end
   end

   always @(negedge CP) begin
      if (chk_en) begin
         check("q",    32'(Q),    32'(m_q));
         check("q_n",  32'(Q_n),  32'((~m_q) & (M - 1)));
         check("cnt",  32'(CNT),  32'(m_cnt));
         check("done", 32'(DONE), 32'(m_done));
      end
   end

   task automatic tick();
      @(posedge CP);
      #2;
   endtask

   task automatic drive(input logic ce, input logic [1:0] s, input logic dsr, input logic dsl,
                        input logic [W-1:0] d);
      CE = ce; S = s; DSR = dsr; DSL = dsl; D = d;
   endtask

   initial begin
      RD = 1'b1; ROT = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
      tick(); tick();
      check("rst_q",    32'(Q),    32'h00);
      check("rst_qn",   32'(Q_n),  32'hFF);
      check("rst_cnt",  32'(CNT),  32'h0);
      check("rst_done", 32'(DONE), 32'h0);
      RD = 1'b0;
      chk_en = 1'b1;

      // Async reset between edges
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
      tick();
      check("load_a5", 32'(Q), 32'hA5);
      RD = 1'b1;
      #1;
      check("async_q",   32'(Q),   32'h00);
      check("async_qn",  32'(Q_n), 32'hFF);
      check("async_cnt", 32'(CNT), 32'h0);
      RD = 1'b0;

      // Load then hold
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
      tick();
      S = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_q",    32'(Q),    32'h3C);
         check("hold_cnt",  32'(CNT),  32'h0);
         check("hold_done", 32'(DONE), 32'h0);
      end

      // Shift right from 81 with DSR=1
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
      tick();
      drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
      tick();
      check("sr1_q",   32'(Q),   32'h03);
      check("sr1_cnt", 32'(CNT), 32'h1);
      for (int n = 2; n <= 8; n++) begin
         tick();
         check("sr_cnt",  32'(CNT),  32'(n));
         check("sr_done", 32'(DONE), (n == 8) ? 32'h1 : 32'h0);
      end
      check("sr8_q",   32'(Q),   32'hFF);
      check("model_q", 32'(m_q), 32'hFF);

      // Saturation, then reload
      drive(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_cnt",  32'(CNT),  32'h8);
         check("sat_done", 32'(DONE), 32'h0);
      end
      check("sat_q", 32'(Q), 32'h1F);
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h55);
      tick();
      check("reload_q",   32'(Q),   32'h55);
      check("reload_cnt", 32'(CNT), 32'h0);

      // CE gating with a completion pending
      drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
      repeat (7) tick();
      check("pre_cnt", 32'(CNT), 32'h7);
      check("pre_q",   32'(Q),   32'h80);
      CE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ce_q",    32'(Q),    32'h80);
         check("ce_cnt",  32'(CNT),  32'h7);
         check("ce_done", 32'(DONE), 32'h0);
      end
      CE = 1'b1;
      tick();
      check("ce_resume_done", 32'(DONE), 32'h1);
      check("ce_resume_cnt",  32'(CNT),  32'h8);

      // Load on pending completion suppresses DONE
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hF0);
      tick();
      S = 2'b01;
      repeat (7) tick();
      S = 2'b11; D = 8'h12;
      tick();
      check("ldpend_cnt",  32'(CNT),  32'h0);
      check("ldpend_done", 32'(DONE), 32'h0);
      check("ldpend_q",    32'(Q),    32'h12);

      // Reset in the middle of a shift sequence
      S = 2'b10; DSL = 1'b1;
      repeat (3) tick();
      RD = 1'b1;
      #1;
      check("mid_rst_q",   32'(Q),   32'h00);
      check("mid_rst_cnt", 32'(CNT), 32'h0);
      tick();
      RD = 1'b0;

`ifdef SYSU_SHREG_ROTATE_EN
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
      tick();
      ROT = 1'b1; S = 2'b10; DSL = 1'b0;
      tick();
      check("rot1_q", 32'(Q), 32'hC0);
      for (int n = 2; n <= 8; n++) begin
         tick();
         check("rot_done", 32'(DONE), (n == 8) ? 32'h1 : 32'h0);
      end
      check("rot8_q", 32'(Q), 32'h81);
      ROT = 1'b0;
`endif

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 8'($urandom));
`ifdef SYSU_SHREG_ROTATE_EN
         ROT = 1'($urandom);
`endif
         // Bias toward long shift runs so the counter reaches saturation
         if (i % 40 < 25 && S == 2'b11) S = 2'b01;
         if ($urandom_range(0, 59) == 0) begin
            #1 RD = 1'b1;
            #1 RD = 1'b0;
         end
         tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
